// File: rtl/speck32_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : speck32_enc_core (with helper speck32_add16)
// Brief    : Iterative SPECK32/64 encryptor, one round per clock, with
//            valid/ready handshakes on both sides. Optional macro
//            SPECK_UNROLL2_EN chains two rounds per clock.
// Revision : 1.0
// ============================================================================

module speck32_add16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);
    // Carry-out intentionally dropped: SPECK arithmetic is mod 2^16.
    assign o_sum = i_a + i_b;
endmodule

module speck32_enc_core #(
    parameter int ROUNDS = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] key,
    input  logic [31:0] pt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ct,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_k;
    logic [15:0] r_l0;
    logic [15:0] r_l1;
    logic [15:0] r_l2;
    logic [4:0]  r_rnd;
    logic [31:0] r_ct;
    logic        r_out_valid;
    logic        r_busy;

    function automatic logic [15:0] ror7(input logic [15:0] v);
        return {v[6:0], v[15:7]};
    endfunction

    function automatic logic [15:0] rol2(input logic [15:0] v);
        return {v[13:0], v[15:14]};
    endfunction

    // First round stage (round index r_rnd)
    logic [15:0] w_sum_x1;
    logic [15:0] w_sum_k1;
    logic [15:0] w_x1;
    logic [15:0] w_y1;
    logic [15:0] w_lnew1;
    logic [15:0] w_k1;

    speck32_add16 u_add_x1 (.i_a(ror7(r_x)), .i_b(r_y),        .o_sum(w_sum_x1));
    speck32_add16 u_add_k1 (.i_a(r_k),       .i_b(ror7(r_l0)), .o_sum(w_sum_k1));

    assign w_x1    = w_sum_x1 ^ r_k;
    assign w_y1    = rol2(r_y) ^ w_x1;
    assign w_lnew1 = w_sum_k1 ^ {11'd0, r_rnd};
    assign w_k1    = rol2(r_k) ^ w_lnew1;

    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic [15:0] w_k_nxt;
    logic [15:0] w_l0_nxt;
    logic [15:0] w_l1_nxt;
    logic [15:0] w_l2_nxt;
    logic [4:0]  w_rnd_nxt;
    logic        w_last;

`ifdef SPECK_UNROLL2_EN
    localparam logic [4:0] c_LAST = 5'(ROUNDS - 2);

    if ((ROUNDS % 2) != 0) begin : g_odd_rounds
        $error("speck32_enc_core: ROUNDS must be even with two rounds per cycle");
    end

    // Second round stage (round index r_rnd+1); its l[0] is the shifted r_l1.
    logic [15:0] w_sum_x2;
    logic [15:0] w_sum_k2;
    logic [15:0] w_x2;
    logic [15:0] w_y2;
    logic [15:0] w_lnew2;
    logic [15:0] w_k2;
    logic [4:0]  w_rnd1;

    assign w_rnd1 = r_rnd + 5'd1;

    speck32_add16 u_add_x2 (.i_a(ror7(w_x1)), .i_b(w_y1),       .o_sum(w_sum_x2));
    speck32_add16 u_add_k2 (.i_a(w_k1),       .i_b(ror7(r_l1)), .o_sum(w_sum_k2));

    assign w_x2    = w_sum_x2 ^ w_k1;
    assign w_y2    = rol2(w_y1) ^ w_x2;
    assign w_lnew2 = w_sum_k2 ^ {11'd0, w_rnd1};
    assign w_k2    = rol2(w_k1) ^ w_lnew2;

    assign w_x_nxt   = w_x2;
    assign w_y_nxt   = w_y2;
    assign w_k_nxt   = w_k2;
    assign w_l0_nxt  = r_l2;
    assign w_l1_nxt  = w_lnew1;
    assign w_l2_nxt  = w_lnew2;
    assign w_rnd_nxt = r_rnd + 5'd2;
`else
    localparam logic [4:0] c_LAST = 5'(ROUNDS - 1);

    assign w_x_nxt   = w_x1;
    assign w_y_nxt   = w_y1;
    assign w_k_nxt   = w_k1;
    assign w_l0_nxt  = r_l1;
    assign w_l1_nxt  = r_l2;
    assign w_l2_nxt  = w_lnew1;
    assign w_rnd_nxt = r_rnd + 5'd1;
`endif

    assign w_last = (r_rnd == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_k         <= '0;
            r_l0        <= '0;
            r_l1        <= '0;
            r_l2        <= '0;
            r_rnd       <= '0;
            r_ct        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= pt[31:16];
                        r_y     <= pt[15:0];
                        r_k     <= key[15:0];
                        r_l0    <= key[31:16];
                        r_l1    <= key[47:32];
                        r_l2    <= key[63:48];
                        r_rnd   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_k   <= w_k_nxt;
                    r_l0  <= w_l0_nxt;
                    r_l1  <= w_l1_nxt;
                    r_l2  <= w_l2_nxt;
                    r_rnd <= w_rnd_nxt;
                    if (w_last) begin
                        r_ct        <= {w_x_nxt, w_y_nxt};
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign ct        = r_ct;

endmodule
`default_nettype wire

// File: tb/tb_speck32_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_speck32_enc_core
// Brief    : Self-checking bench for speck32_enc_core with a software SPECK
//            reference feeding an expected-ciphertext queue.
// Revision : 1.0
// ============================================================================
module tb_speck32_enc_core;

    localparam int ROUNDS = 22;
`ifdef SPECK_UNROLL2_EN
    localparam int LAT = ROUNDS / 2;
`else
    localparam int LAT = ROUNDS;
`endif
    localparam int NRAND = 1000;
    localparam logic [63:0] STD_KEY = 64'h1918111009080100;
    localparam logic [31:0] STD_PT  = 32'h6574694c;
    localparam logic [31:0] STD_CT  = 32'ha86842f2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] key;
    logic [31:0] pt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ct;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_q[$];

    speck32_enc_core #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .key      (key),
        .pt       (pt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ct       (ct),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] f_ror7(input logic [15:0] v);
        return (v >> 7) | (v << 9);
    endfunction

    function automatic logic [15:0] f_rol2(input logic [15:0] v);
        return (v << 2) | (v >> 14);
    endfunction

    function automatic logic [31:0] speck_ref(input logic [63:0] k64, input logic [31:0] p);
        logic [15:0] x, y, k, l0, l1, l2, t;
        x = p[31:16]; y = p[15:0];
        k = k64[15:0]; l0 = k64[31:16]; l1 = k64[47:32]; l2 = k64[63:48];
        for (int i = 0; i < ROUNDS; i++) begin
            x = (f_ror7(x) + y) ^ k;
            y = f_rol2(y) ^ x;
            t = (k + f_ror7(l0)) ^ 16'(i);
            k = f_rol2(k) ^ t;
            l0 = l1; l1 = l2; l2 = t;
        end
        return {x, y};
    endfunction

    // Offer a block at a falling edge; returns at the falling edge after accept.
    task automatic send(input logic [63:0] k, input logic [31:0] p);
        int n;
        n = 0;
        in_valid = 1'b1; key = k; pt = p;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b required 1 within 200 cycles", in_ready);
        end else begin
            acc_cyc = cyc + 1;
            exp_q.push_back(speck_ref(k, p));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = out_valid ? (cyc - acc_cyc) : -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key = '0; pt = '0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ct !== 32'h0) begin errors++; $display("FAIL reset_ct: got %h want 00000000", ct); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_std_vector;
        int lat;
        logic [31:0] e;
        out_ready = 1'b1;
        send(STD_KEY, STD_PT);
        wait_valid(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL std_latency: got %0d want %0d", lat, LAT); end
        e = exp_q.pop_front();
        checks++; if (ct !== e) begin errors++; $display("FAIL std_ct_model: got %h want %h", ct, e); end
        checks++; if (ct !== STD_CT) begin errors++; $display("FAIL std_ct_vector: got %h want %h", ct, STD_CT); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] e;
        out_ready = 1'b0;
        send(STD_KEY, STD_PT);
        wait_valid(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (ct !== STD_CT) begin errors++; $display("FAIL bp_ct[%0d]: got %h want %h", i, ct, STD_CT); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        checks++; if (ct !== e) begin errors++; $display("FAIL bp_ct_model: got %h want %h", ct, e); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_input;
        int lat;
        logic [31:0] e;
        out_ready = 1'b1;
        send(STD_KEY, STD_PT);
        for (int i = 0; i < LAT - 3; i++) begin
            in_valid = 1'b1;
            key = {$urandom, $urandom};
            pt  = $urandom;
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++; if (lat != LAT) begin errors++; $display("FAIL ign_latency: got %0d want %0d", lat, LAT); end
        checks++; if (ct !== STD_CT || ct !== e) begin errors++; $display("FAIL ign_ct: got %h want %h", ct, STD_CT); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL ign_no_second_accept[%0d]: busy=%b in_ready=%b want 0/1", i, busy, in_ready);
            end
        end
    endtask

    task automatic test_mid_reset;
        int lat;
        int stray;
        logic [31:0] e;
        out_ready = 1'b1;
        send(STD_KEY, STD_PT);
        repeat (LAT / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mrst_state: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
        end
        checks++; if (ct !== 32'h0) begin errors++; $display("FAIL mrst_ct: got %h want 00000000", ct); end
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mrst_stray_out_valid: got %0d cycles want 0", stray); end
        send(64'h0, 32'h0);
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++; if (lat != LAT) begin errors++; $display("FAIL mrst_latency: got %0d want %0d", lat, LAT); end
        checks++; if (ct !== e) begin errors++; $display("FAIL mrst_zero_ct: got %h want %h", ct, e); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n, nacc, nout, busy_cnt, a1, a2;
        bit pending;
        logic [31:0] e;
        n = 0; nacc = 0; nout = 0; busy_cnt = 0; a1 = 0; a2 = 0; pending = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; key = STD_KEY; pt = STD_PT;
        while (nout < 2 && n < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (ct !== e) begin errors++; $display("FAIL b2b_ct[%0d]: got %h want %h", nout, ct, e); end
                if (nout == 0) begin
                    checks++; if (ct !== STD_CT) begin errors++; $display("FAIL b2b_ct_vector: got %h want %h", ct, STD_CT); end
                end
                nout++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(speck_ref(key, pt));
                nacc++;
                if (nacc == 1) a1 = cyc + 1; else a2 = cyc + 1;
                pending = 1'b1;
            end else if (pending) begin
                pending = 1'b0;
                if (nacc == 1) begin
                    key = 64'h0123456789abcdef; pt = 32'hdeadbeef;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        checks++; if (nout != 2) begin errors++; $display("FAIL b2b_outputs: got %0d want 2", nout); end
        checks++; if (a2 - a1 != LAT + 2) begin errors++; $display("FAIL b2b_accept_gap: got %0d want %0d", a2 - a1, LAT + 2); end
        checks++; if (busy_cnt != 2 * LAT) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want %0d", busy_cnt, 2 * LAT); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random;
        fork
            begin
                for (int b = 0; b < NRAND; b++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send({$urandom, $urandom}, $urandom);
                end
            end
            begin
                int got, n;
                logic [31:0] e;
                got = 0; n = 0;
                while (got < NRAND && n < 40000) begin
                    @(negedge clk);
                    n++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_unexpected_output: got %h with empty queue", ct);
                        end else begin
                            e = exp_q.pop_front();
                            if (ct !== e) begin errors++; $display("FAIL rand_ct[%0d]: got %h want %h", got, ct, e); end
                        end
                        got++;
                    end
                end
                checks++;
                if (got != NRAND) begin errors++; $display("FAIL rand_count: got %0d want %0d", got, NRAND); end
                out_ready = 1'b1;
            end
        join
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_std_vector();
        test_backpressure();
        test_ignored_input();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/speck32_enc_core.md
# speck32_enc_core

Iterative SPECK32/64 encryption engine for the SPECK datapath. It accepts one 32-bit plaintext block and one 64-bit key through a valid/ready handshake. It runs the round function and the on-the-fly key schedule one round per clock, and returns the ciphertext through a second valid/ready handshake. All mod-2^16 additions go through the team's 16-bit carry-less-overflow adder stage, instantiated twice: once for the round function and once for the key schedule.

## Interface
Parameters:
- ROUNDS, 22, number of rounds executed; legal range 1..31.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext/key offer.
- in_ready  output  1  core can accept a new block.
- key  input  64  key words {l2,l1,l0,k0}, with k0 = key[15:0], l0 = key[31:16], l1 = key[47:32], l2 = key[63:48].
- pt  input  32  plaintext {x,y}, with x = pt[31:16] and y = pt[15:0].
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts the ciphertext.
- ct  output  32  ciphertext {x,y}.
- busy  output  1  high while in RUN.

## Operation
- FSM states:
  - IDLE: in_ready = 1.
  - RUN: rounds are executing.
  - DONE: out_valid = 1, ct holds the result.
- Accept is in_valid && in_ready at a rising edge. On accept, load x, y, k ← k0, l[0..2] ← l0, l1, l2 and rnd ← 0, then go IDLE→RUN.
- Each RUN cycle, with i = rnd:
  - x' = (ROR7(x) + y) ^ k
  - y' = ROL2(y) ^ x'
  - lnew = (k + ROR7(l[0])) ^ i (i zero-extended to 16 bits)
  - k' = ROL2(k) ^ lnew
  - Shift the l pipe: l[0] ← l[1], l[1] ← l[2], l[2] ← lnew.
  - rnd ← rnd + 1.
- All additions are mod 2^16 and the carry-out is discarded. rnd is 5 bits.
- When the round with i = ROUNDS−1 completes, go RUN→DONE; ct = {x,y} is registered.
- DONE→IDLE on out_ready. ct keeps its value until the next accept.
- In RUN and DONE, in_valid is ignored (in_ready = 0). key and pt are sampled only at the accept edge.
- out_ready is ignored outside DONE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, ct 0, and all internal registers 0.
- Reset asserted at any point, including mid-RUN or in DONE, aborts immediately. No partial output is produced and no out_valid pulse occurs.
- Latency: if accept happens at edge E, out_valid rises after edge E+ROUNDS (22 cycles by default).
- Throughput: one block per ROUNDS+2 cycles when out_ready is held high. The DONE→IDLE and IDLE→accept transitions take one edge each, so there is no back-to-back accept from DONE.
- out_valid stays high, and ct stays stable, while out_ready is low. Indefinite stall is allowed.
- in_ready is combinational from state only, with no combinational path from out_ready.

## Configuration
- SPECK_UNROLL2_EN defined:
  - Two round stages are chained per cycle, giving four adder instances.
  - rnd advances by 2 per cycle.
  - ROUNDS must be even; an odd value is a synthesis-time error.
  - Latency is ROUNDS/2 cycles (11 by default). Handshake and reset behaviour are unchanged.
- SPECK_UNROLL2_EN not defined: one round per cycle as described above.

## Test plan
- Standard vector: key = 0x1918111009080100, pt = 0x6574694c, out_ready = 1 → ct = 0xa86842f2, out_valid exactly 22 cycles after accept (11 with SPECK_UNROLL2_EN).
- Backpressure: same vector with out_ready held low for 10 cycles after out_valid → ct stays 0xa86842f2, out_valid stays high, in_ready = 0, and the FSM returns to IDLE one edge after out_ready goes high.
- Ignored input: change in_valid/pt/key mid-RUN → result is still 0xa86842f2 and no second accept occurs.
- Mid-run reset: assert rst at round 10, release it, then apply key = 0 and pt = 0 → in_ready = 1 right after reset, no stray out_valid, and ct matches the golden model for the zero key/plaintext.
- Back-to-back: two vectors with in_valid held high and out_ready = 1 → second accept occurs 24 cycles after the first, both ciphertexts are correct, and busy is high exactly 22 cycles per block.
- Randomized: 1000 random key/pt pairs with random out_ready stalls → ct matches the software SPECK32/64 reference for every block.
